// File: rtl/exponent_host_master.sv
// Avalon-MM master that runs one exponent job: it writes x, a and start, polls status, then reads p back.
// Latency: 8 cycles from request accept to rsp_valid with no stalls, read latency 1 and done on the first poll.
// Backpressure: waitrequest holds the strobe, address and data; req_ready is low until the result is acked.
//
// Ports:
//   clk, reset                          clock and synchronous active-high reset
//   req_valid/req_ready, req_x, req_a   upstream job handshake and operands
//   rsp_valid/rsp_ack, rsp_p, rsp_err   result handshake; rsp_err flags a poll timeout
//   avm_*                               Avalon-MM master port to the accelerator slave
module exponent_host_master #(
    parameter logic [3:0] ADDR_X    = 4'd0,
    parameter logic [3:0] ADDR_A    = 4'd1,
    parameter logic [3:0] ADDR_CTRL = 4'd2,
    parameter logic [3:0] ADDR_STAT = 4'd3,
    parameter logic [3:0] ADDR_P    = 4'd4,
    parameter int         MAX_POLLS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_a,
    output logic        rsp_valid,
    input  logic        rsp_ack,
    output logic [31:0] rsp_p,
    output logic        rsp_err,
    output logic [3:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest
);

    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);

    typedef enum logic [3:0] {
        IDLE, WR_X, WR_A, WR_GO, RD_STAT, WT_STAT, RD_P, WT_P, RESP
    } state_t;

    state_t        state;
    logic [31:0]   a_q;
    logic [PW-1:0] poll_cnt;

    // All bus and handshake outputs are registered here. Each state sets up
    // the strobe for the next state, so each transfer is presented on the
    // cycle after the previous one completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            a_q           <= '0;
            poll_cnt      <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_p         <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        // x goes straight onto the bus, so only a is kept.
                        a_q           <= req_a;
                        req_ready     <= 1'b0;
                        avm_write     <= 1'b1;
                        avm_address   <= ADDR_X;
                        avm_writedata <= req_x;
                        state         <= WR_X;
                    end
                end
                WR_X: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= ADDR_A;
                        avm_writedata <= a_q;
                        state         <= WR_A;
                    end
                end
                WR_A: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= ADDR_CTRL;
                        avm_writedata <= 32'd1;
                        state         <= WR_GO;
                    end
                end
                WR_GO: begin
                    if (!avm_waitrequest) begin
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                        avm_read      <= 1'b1;
                        avm_address   <= ADDR_STAT;
                        state         <= RD_STAT;
                    end
                end
                RD_STAT: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= WT_STAT;
                    end
                end
                WT_STAT: begin
                    if (avm_readdatavalid) begin
                        if (avm_readdata[0]) begin
                            avm_read    <= 1'b1;
                            avm_address <= ADDR_P;
                            state       <= RD_P;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            if (poll_cnt + 1'b1 == POLL_LIMIT) begin
                                // Slave never reported done: give up without reading p.
                                rsp_err   <= 1'b1;
                                rsp_p     <= '0;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end else begin
                                avm_read    <= 1'b1;
                                avm_address <= ADDR_STAT;
                                state       <= RD_STAT;
                            end
                        end
                    end
                end
                RD_P: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= WT_P;
                    end
                end
                WT_P: begin
                    if (avm_readdatavalid) begin
                        rsp_p     <= avm_readdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ack) begin
                        rsp_valid <= 1'b0;
                        poll_cnt  <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exponent_host_master.sv
`timescale 1ns/1ps
module tb_exponent_host_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_x, req_a;
    logic        rsp_valid, rsp_ack;
    logic [31:0] rsp_p;
    logic        rsp_err;
    logic [3:0]  avm_address;
    logic        avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    exponent_host_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_a(req_a),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_p(rsp_p), .rsp_err(rsp_err),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [31:0] p; logic err; } rsp_t;
    wr_t  exp_wr_q[$];
    rsp_t exp_rsp_q[$];

    // Slave model configuration and observations.
    int stall_n = 0, stall_left = 0, rd_lat = 1, done_after = 1;
    int pend = 0, stat_reads = 0, p_reads = 0;
    int rw_both = 0, stall_breaks = 0, stall_cycles = 0, extra_wr = 0;
    logic [31:0] pend_data = '0, reg_x = '0, reg_a = '0, reg_p = '0;
    logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
    logic [3:0]  prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    function automatic logic [31:0] pw(input logic [31:0] b, input logic [31:0] e);
        logic [31:0] r = 32'd1;
        for (int i = 0; i < int'(e); i++) r = r * b;
        return r;
    endfunction

    // Slave drives its outputs on the falling edge; DUT samples them on the rising edge.
    always @(negedge clk) begin
        wr_t w;
        if (avm_read && avm_write) rw_both++;
        if (prev_stall && (avm_read !== prev_rd || avm_write !== prev_wr ||
                           avm_address !== prev_addr ||
                           (prev_wr && avm_writedata !== prev_wdata)))
            stall_breaks++;
        prev_stall = 1'b0;
        avm_readdatavalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = pend_data;
            end
        end
        if (!reset && (avm_read || avm_write)) begin
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
                stall_cycles++;
                prev_stall = 1'b1;
                prev_rd    = avm_read;
                prev_wr    = avm_write;
                prev_addr  = avm_address;
                prev_wdata = avm_writedata;
            end else begin
                avm_waitrequest = 1'b0;
                stall_left      = stall_n;
                if (avm_write) begin
                    if (exp_wr_q.size() == 0) extra_wr++;
                    else begin
                        w = exp_wr_q.pop_front();
                        chk("wr_addr", {28'd0, avm_address}, {28'd0, w.addr});
                        chk("wr_data", avm_writedata, w.data);
                    end
                    case (avm_address)
                        4'd0: reg_x = avm_writedata;
                        4'd1: reg_a = avm_writedata;
                        4'd2: if (avm_writedata == 32'd1) reg_p = pw(reg_x, reg_a);
                        default: ;
                    endcase
                end else begin
                    pend = rd_lat;
                    if (avm_address == 4'd3) begin
                        stat_reads++;
                        pend_data = {31'd0, stat_reads >= done_after};
                    end else if (avm_address == 4'd4) begin
                        p_reads++;
                        pend_data = reg_p;
                    end else pend_data = '0;
                end
            end
        end else avm_waitrequest = 1'b0;
    end

    task automatic cfg(input int s, input int lat, input int done);
        stall_n = s; stall_left = s; rd_lat = lat; done_after = done;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({pfx, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
        chk({pfx, "_rsp_p"},     rsp_p,              32'd0);
        chk({pfx, "_avm_read"},  {31'd0, avm_read},  32'd0);
        chk({pfx, "_avm_write"}, {31'd0, avm_write}, 32'd0);
        chk({pfx, "_avm_addr"},  {28'd0, avm_address}, 32'd0);
        chk({pfx, "_avm_wdata"}, avm_writedata,      32'd0);
    endtask

    // Called on a falling edge; returns on a falling edge after acceptance.
    task automatic submit(input logic [31:0] x, input logic [31:0] a, input logic [31:0] ep,
                          input logic ee, input bit want_rsp, output int acc);
        bit ok = 1'b0;
        acc = 0;
        stat_reads = 0; p_reads = 0;
        exp_wr_q.push_back(wr_t'{4'd0, x});
        exp_wr_q.push_back(wr_t'{4'd1, a});
        exp_wr_q.push_back(wr_t'{4'd2, 32'd1});
        if (want_rsp) exp_rsp_q.push_back(rsp_t'{ep, ee});
        req_x = x; req_a = a; req_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (req_ready) begin acc = cyc; ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("req_accepted", {31'd0, ok}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int acc, input int exp_lat, input int ack_delay);
        bit   got = 1'b0;
        int   bad = 0;
        rsp_t e;
        logic [31:0] p0;
        for (int n = 0; n < 2000; n++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("rsp_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        if (exp_lat >= 0) chk("latency", cyc - acc, exp_lat);
        if (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            chk("rsp_p", rsp_p, e.p);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end else chk("rsp_expected", exp_rsp_q.size(), 32'd1);
        p0 = rsp_p;
        repeat (ack_delay) begin
            @(negedge clk);
            if (!rsp_valid || rsp_p !== p0 || req_ready) bad++;
        end
        if (ack_delay > 0) chk("rsp_hold", bad, 32'd0);
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("ready_after_ack", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int acc, acc2, bad;
        bit seen;
        reset = 1'b1; req_valid = 1'b0; req_x = '0; req_a = '0; rsp_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Basic job.
        cfg(0, 1, 1);
        submit(32'd3, 32'd4, 32'd81, 1'b0, 1'b1, acc);
        wait_rsp(acc, 8, 0);
        chk("basic_stat_reads", stat_reads, 32'd1);
        chk("basic_p_reads", p_reads, 32'd1);

        // Two-cycle stall on every transfer.
        cfg(2, 1, 1); stall_breaks = 0; stall_cycles = 0;
        submit(32'd2, 32'd10, 32'd1024, 1'b0, 1'b1, acc);
        wait_rsp(acc, 18, 0);
        chk("stall_stable", stall_breaks, 32'd0);
        chk("stall_cycles", stall_cycles, 32'd10);

        // Done only on the fifth poll.
        cfg(0, 1, 5);
        submit(32'd7, 32'd0, 32'd1, 1'b0, 1'b1, acc);
        wait_rsp(acc, -1, 0);
        chk("slow_stat_reads", stat_reads, 32'd5);
        chk("slow_p_reads", p_reads, 32'd1);

        // Done never set: poll timeout.
        cfg(0, 1, 1000);
        submit(32'd9, 32'd9, 32'd0, 1'b1, 1'b1, acc);
        wait_rsp(acc, -1, 0);
        chk("tmo_stat_reads", stat_reads, 32'd16);
        chk("tmo_p_reads", p_reads, 32'd0);

        // Slow ack with req_valid held high: second job starts right after ack.
        cfg(0, 1, 1);
        submit(32'd3, 32'd2, 32'd9, 1'b0, 1'b1, acc);
        exp_wr_q.push_back(wr_t'{4'd0, 32'd5});
        exp_wr_q.push_back(wr_t'{4'd1, 32'd3});
        exp_wr_q.push_back(wr_t'{4'd2, 32'd1});
        exp_rsp_q.push_back(rsp_t'{32'd125, 1'b0});
        req_x = 32'd5; req_a = 32'd3; req_valid = 1'b1;
        wait_rsp(acc, 8, 10);
        acc2 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(acc2, 8, 0);

        // Reset while waiting for status data; the late readdatavalid must be ignored.
        cfg(0, 3, 1);
        submit(32'd4, 32'd4, 32'd0, 1'b0, 1'b0, acc);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (stat_reads >= 1 && !avm_read) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("reached_wt_stat", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid");
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || avm_read || avm_write) bad++;
        end
        chk("stray_ignored", bad, 32'd0);
        cfg(0, 1, 1);
        submit(32'd2, 32'd3, 32'd8, 1'b0, 1'b1, acc);
        wait_rsp(acc, 8, 0);

        chk("rw_exclusive", rw_both, 32'd0);
        chk("no_extra_writes", extra_wr, 32'd0);
        chk("writes_drained", exp_wr_q.size(), 32'd0);
        chk("rsps_drained", exp_rsp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
